// File: rtl/matrix_pkg.sv
// Shared LED-matrix definitions: geometry, framebuffer command opcodes and writer FSM states.
// Used by the framebuffer writer, the row-scan driver and the game logic.
package matrix_pkg;

  localparam int unsigned MATRIX_ROWS = 16;
  localparam int unsigned MATRIX_COLS = 16;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_SET    = 3'd1,
    OP_CLR    = 3'd2,
    OP_TOG    = 3'd3,
    OP_WROW   = 3'd4,
    OP_CLRALL = 3'd5,
    OP_SWAP   = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_e;

  // Opcodes that edit a single back-buffer row in one cycle.
  function automatic logic is_row_edit(input op_e op);
    return (op == OP_SET) || (op == OP_CLR) || (op == OP_TOG) || (op == OP_WROW);
  endfunction

endpackage

// File: rtl/fb_row_editor.sv
// Combinational single-row update for the framebuffer writer: applies SET/CLR/TOGGLE at column x
// or replaces the whole row, and flags whether the row should be written back (range-checked).
module fb_row_editor
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = MATRIX_ROWS,
  parameter int unsigned COLS = MATRIX_COLS,
  parameter int unsigned X_W  = 4,
  parameter int unsigned Y_W  = 4
) (
  input  logic [COLS-1:0] row_in,
  input  logic [2:0]      op,
  input  logic [X_W-1:0]  x,
  input  logic [Y_W-1:0]  y,
  input  logic [COLS-1:0] data,
  output logic [COLS-1:0] row_out,
  output logic            row_we
);

  logic x_ok;
  logic y_ok;

  always_comb begin
    x_ok    = int'(x) < int'(COLS);
    y_ok    = int'(y) < int'(ROWS);
    row_out = row_in;
    row_we  = 1'b0;
    case (op_e'(op))
      OP_SET: begin
        if (x_ok && y_ok) begin
          row_out[x] = 1'b1;
          row_we     = 1'b1;
        end
      end
      OP_CLR: begin
        if (x_ok && y_ok) begin
          row_out[x] = 1'b0;
          row_we     = 1'b1;
        end
      end
      OP_TOG: begin
        if (x_ok && y_ok) begin
          row_out[x] = ~row_in[x];
          row_we     = 1'b1;
        end
      end
      // Whole-row write only needs a valid row.
      OP_WROW: begin
        if (y_ok) begin
          row_out = data;
          row_we  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Double-buffered 16x16 LED framebuffer producer: commands edit the back buffer, SWAP copies it to
// the front buffer on the scan driver's frame_sync. Define FB_READBACK_EN for back-buffer readback.
module framebuffer_writer
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = MATRIX_ROWS,
  parameter int unsigned COLS = MATRIX_COLS,
  parameter int unsigned X_W  = 4,
  parameter int unsigned Y_W  = 4
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [X_W-1:0]       cmd_x,
  input  logic [Y_W-1:0]       cmd_y,
  input  logic [COLS-1:0]      cmd_data,
  input  logic                 frame_sync,
  output logic [ROWS*COLS-1:0] framebuffer,
  output logic                 busy,
  output logic                 swap_done
`ifdef FB_READBACK_EN
  ,
  input  logic [X_W-1:0]       rd_x,
  input  logic [Y_W-1:0]       rd_y,
  output logic                 rd_pixel
`endif
);

  state_e                       state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]    back_q, back_d;
  logic [ROWS-1:0][COLS-1:0]    front_q, front_d;
  logic [Y_W-1:0]               clr_row_q, clr_row_d;
  logic                         cmd_ready_q;
  logic                         busy_q;
  logic                         swap_done_q, swap_done_d;

  logic                         accept;
  op_e                          op;
  logic [COLS-1:0]              edit_row;
  logic                         edit_we;

  assign accept = cmd_valid && cmd_ready_q;
  assign op     = op_e'(cmd_op);

  fb_row_editor #(
    .ROWS (ROWS),
    .COLS (COLS),
    .X_W  (X_W),
    .Y_W  (Y_W)
  ) u_row_editor (
    .row_in  (back_q[cmd_y]),
    .op      (cmd_op),
    .x       (cmd_x),
    .y       (cmd_y),
    .data    (cmd_data),
    .row_out (edit_row),
    .row_we  (edit_we)
  );

  always_comb begin
    state_d     = state_q;
    back_d      = back_q;
    front_d     = front_q;
    clr_row_d   = clr_row_q;
    swap_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_row_edit(op) && edit_we) begin
            back_d[cmd_y] = edit_row;
          end
          if (op == OP_CLRALL) begin
            state_d   = ST_CLEAR;
            clr_row_d = '0;
          end else if (op == OP_SWAP) begin
            state_d = ST_SWAP_WAIT;
          end
        end
      end
      ST_CLEAR: begin
        back_d[clr_row_q] = '0;
        clr_row_d         = clr_row_q + 1'b1;
        if (clr_row_q == Y_W'(ROWS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      // Only reachable one edge after the SWAP accept, so a coincident sync is never seen here.
      ST_SWAP_WAIT: begin
        if (frame_sync) begin
          front_d     = back_q;
          swap_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      back_q      <= '0;
      front_q     <= '0;
      clr_row_q   <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      back_q      <= back_d;
      front_q     <= front_d;
      clr_row_q   <= clr_row_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      swap_done_q <= swap_done_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign swap_done   = swap_done_q;
  assign framebuffer = front_q;

`ifdef FB_READBACK_EN
  logic rd_pixel_q;

  // Reads back_q, so a same-cycle write to the pixel returns the pre-write value.
  always_ff @(posedge system_clk) begin
    if (!rst) begin
      rd_pixel_q <= 1'b0;
    end else if ((int'(rd_x) < int'(COLS)) && (int'(rd_y) < int'(ROWS))) begin
      rd_pixel_q <= back_q[rd_y][rd_x];
    end else begin
      rd_pixel_q <= 1'b0;
    end
  end

  assign rd_pixel = rd_pixel_q;
`endif

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: vector table for command/swap behaviour plus hand-written
// CLEAR_ALL, reset-abort and (with FB_READBACK_EN) readback sequences.
module tb_framebuffer_writer;
  import matrix_pkg::*;

  logic         system_clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [3:0]   cmd_x;
  logic [3:0]   cmd_y;
  logic [15:0]  cmd_data;
  logic         frame_sync;
  logic [255:0] framebuffer;
  logic         busy;
  logic         swap_done;
`ifdef FB_READBACK_EN
  logic [3:0]   rd_x;
  logic [3:0]   rd_y;
  logic         rd_pixel;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 system_clk = ~system_clk;

  framebuffer_writer #(
    .ROWS (16),
    .COLS (16),
    .X_W  (4),
    .Y_W  (4)
  ) dut (
    .system_clk  (system_clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_data    (cmd_data),
    .frame_sync  (frame_sync),
    .framebuffer (framebuffer),
    .busy        (busy),
    .swap_done   (swap_done)
`ifdef FB_READBACK_EN
    ,
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_pixel    (rd_pixel)
`endif
  );

  typedef struct {
    string        name;
    logic         valid;
    logic [2:0]   op;
    logic [3:0]   x;
    logic [3:0]   y;
    logic [15:0]  data;
    logic         sync;
    logic         exp_ready;
    logic         exp_busy;
    logic         exp_done;
    logic [255:0] exp_fb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic valid, input logic [2:0] op,
                              input logic [3:0] x, input logic [3:0] y, input logic [15:0] data,
                              input logic sync, input logic er, input logic eb, input logic ed,
                              input logic [255:0] efb);
    vec_t v;
    v.name = name; v.valid = valid; v.op = op; v.x = x; v.y = y; v.data = data; v.sync = sync;
    v.exp_ready = er; v.exp_busy = eb; v.exp_done = ed; v.exp_fb = efb;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] x,
                       input logic [3:0] y, input logic [15:0] d, input logic s);
    cmd_valid  = v;
    cmd_op     = op;
    cmd_x      = x;
    cmd_y      = y;
    cmd_data   = d;
    frame_sync = s;
    @(posedge system_clk);
    #1;
  endtask

  task automatic idle(input logic s);
    drive(1'b0, 3'd0, 4'd0, 4'd0, 16'h0, s);
  endtask

  logic [255:0] fb1, fb2, fb3;
  int           low_cnt;

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_data = '0; frame_sync = 1'b0;
`ifdef FB_READBACK_EN
    rd_x = '0; rd_y = '0;
`endif

    fb1 = 256'd1 << 35;
    fb2 = fb1 | (256'hA5A5 << 240);
    fb3 = (256'hA5A5 << 240) | 256'd2;

    // Reset state
    idle(1'b0);
    idle(1'b0);
    check("reset ready", {255'd0, cmd_ready}, 256'd0);
    check("reset busy", {255'd0, busy}, 256'd0);
    check("reset done", {255'd0, swap_done}, 256'd0);
    check("reset fb", framebuffer, 256'd0);
`ifdef FB_READBACK_EN
    check("reset rd_pixel", {255'd0, rd_pixel}, 256'd0);
`endif
    rst = 1'b1;
    idle(1'b0);
    check("ready after release", {255'd0, cmd_ready}, 256'd1);

    //           name          v  op x  y  data     s  rdy bsy dn fb
    vecs.push_back(mk("set32",      1, 1, 3, 2, 16'h0,    0, 1, 0, 0, 256'd0));
    vecs.push_back(mk("swap1",      1, 6, 0, 0, 16'h0,    0, 0, 1, 0, 256'd0));
    vecs.push_back(mk("wait1",      0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 256'd0));
    vecs.push_back(mk("sync1",      0, 0, 0, 0, 16'h0,    1, 1, 0, 1, fb1));
    vecs.push_back(mk("post1",      0, 0, 0, 0, 16'h0,    0, 1, 0, 0, fb1));
    vecs.push_back(mk("syncidle",   0, 0, 0, 0, 16'h0,    1, 1, 0, 0, fb1));
    vecs.push_back(mk("wrow15",     1, 4, 0, 15, 16'hA5A5, 0, 1, 0, 0, fb1));
    vecs.push_back(mk("swapcoin",   1, 6, 0, 0, 16'h0,    1, 0, 1, 0, fb1));
    vecs.push_back(mk("wait2",      0, 0, 0, 0, 16'h0,    0, 0, 1, 0, fb1));
    vecs.push_back(mk("sync2",      0, 0, 0, 0, 16'h0,    1, 1, 0, 1, fb2));
    vecs.push_back(mk("tog00a",     1, 3, 0, 0, 16'h0,    0, 1, 0, 0, fb2));
    vecs.push_back(mk("tog00b",     1, 3, 0, 0, 16'h0,    0, 1, 0, 0, fb2));
    vecs.push_back(mk("tog10",      1, 3, 1, 0, 16'h0,    0, 1, 0, 0, fb2));
    vecs.push_back(mk("clr32",      1, 2, 3, 2, 16'h0,    0, 1, 0, 0, fb2));
    vecs.push_back(mk("rsvd55",     1, 7, 5, 5, 16'hFFFF, 0, 1, 0, 0, fb2));
    vecs.push_back(mk("nop66",      1, 0, 6, 6, 16'hFFFF, 0, 1, 0, 0, fb2));
    vecs.push_back(mk("invset99",   0, 1, 9, 9, 16'h0,    0, 1, 0, 0, fb2));
    vecs.push_back(mk("swap3",      1, 6, 0, 0, 16'h0,    1, 0, 1, 0, fb2));
    vecs.push_back(mk("sync3",      0, 0, 0, 0, 16'h0,    1, 1, 0, 1, fb3));

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].data, vecs[i].sync);
      check($sformatf("v%0d %s ready", i, vecs[i].name), {255'd0, cmd_ready},
            {255'd0, vecs[i].exp_ready});
      check($sformatf("v%0d %s busy", i, vecs[i].name), {255'd0, busy},
            {255'd0, vecs[i].exp_busy});
      check($sformatf("v%0d %s done", i, vecs[i].name), {255'd0, swap_done},
            {255'd0, vecs[i].exp_done});
      check($sformatf("v%0d %s fb", i, vecs[i].name), framebuffer, vecs[i].exp_fb);
    end

    // Fill back buffer, CLEAR_ALL: cmd_ready low for exactly 16 cycles.
    for (int r = 0; r < 16; r++) begin
      drive(1'b1, 3'd4, 4'd0, r[3:0], 16'hFFFF, 1'b0);
    end
    check("fill ready", {255'd0, cmd_ready}, 256'd1);
    drive(1'b1, 3'd5, 4'd0, 4'd0, 16'h0, 1'b0);
    check("clrall busy", {255'd0, busy}, 256'd1);
    low_cnt = 0;
    while (!cmd_ready && low_cnt < 40) begin
      low_cnt++;
      idle(1'b1);
    end
    check("clrall low cycles", 256'(low_cnt), 256'd16);
    check("clrall busy end", {255'd0, busy}, 256'd0);
    check("clrall front untouched", framebuffer, fb3);
    drive(1'b1, 3'd6, 4'd0, 4'd0, 16'h0, 1'b0);
    idle(1'b1);
    check("clrall swap done", {255'd0, swap_done}, 256'd1);
    check("clrall fb", framebuffer, 256'd0);

    // Reset during SWAP_WAIT aborts the swap.
    drive(1'b1, 3'd1, 4'd0, 4'd0, 16'h0, 1'b0);
    drive(1'b1, 3'd6, 4'd0, 4'd0, 16'h0, 1'b0);
    idle(1'b1);
    check("pre-rst fb", framebuffer, 256'd1);
    drive(1'b1, 3'd1, 4'd1, 4'd0, 16'h0, 1'b0);
    drive(1'b1, 3'd6, 4'd0, 4'd0, 16'h0, 1'b0);
    idle(1'b0);
    rst = 1'b0;
    idle(1'b1);
    check("rst abort done", {255'd0, swap_done}, 256'd0);
    check("rst abort fb", framebuffer, 256'd0);
    check("rst abort ready", {255'd0, cmd_ready}, 256'd0);
    rst = 1'b1;
    idle(1'b1);
    check("rst release ready", {255'd0, cmd_ready}, 256'd1);
    check("rst release done", {255'd0, swap_done}, 256'd0);
    drive(1'b1, 3'd6, 4'd0, 4'd0, 16'h0, 1'b0);
    idle(1'b1);
    check("post-rst swap done", {255'd0, swap_done}, 256'd1);
    check("post-rst back cleared", framebuffer, 256'd0);

`ifdef FB_READBACK_EN
    rd_x = 4'd7; rd_y = 4'd4;
    drive(1'b1, 3'd1, 4'd7, 4'd4, 16'h0, 1'b0);
    check("rd pre-write", {255'd0, rd_pixel}, 256'd0);
    idle(1'b0);
    check("rd after set", {255'd0, rd_pixel}, 256'd1);
    rd_x = 4'd8;
    idle(1'b0);
    check("rd x8", {255'd0, rd_pixel}, 256'd0);
    rd_x = 4'd7;
    drive(1'b1, 3'd3, 4'd7, 4'd4, 16'h0, 1'b0);
    check("rd tog pre-write", {255'd0, rd_pixel}, 256'd1);
    idle(1'b0);
    check("rd after tog", {255'd0, rd_pixel}, 256'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
